// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// The master side supplies operands and accepts the product; the slave side is the core.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand_in;
  logic [WIDTH-1:0]     multiplier_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product_out;
  logic                 busy;

  modport master (
    output in_valid, multiplicand_in, multiplier_in, out_ready,
    input  in_ready, out_valid, product_out, busy
  );

  modport slave (
    input  in_valid, multiplicand_in, multiplier_in, out_ready,
    output in_ready, out_valid, product_out, busy
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned multiplier: one shift-and-add step per clock over WIDTH steps.
// Operands are captured on the accept edge. The product is held in a separate
// result register so that it stays stable through IDLE and only changes on entry to DONE.
module shift_add_multiplier #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  // Accumulator layout: {carry, hi[WIDTH-1:0], lo[WIDTH-1:0]}; lo starts as the multiplier.
  logic [2*WIDTH:0]     acc_reg, acc_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;

  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     step;
  logic                 operand_zero;

  // One iteration: conditionally add the multiplicand into {carry,hi}, then shift right.
  // The carry is always 0 between steps, so the WIDTH+1-bit sum never overflows.
  assign addend = acc_reg[0] ? {1'b0, mcand_reg} : '0;
  assign sum    = acc_reg[2*WIDTH:WIDTH] + addend;
  assign step   = {1'b0, sum, acc_reg[WIDTH-1:1]};

  assign operand_zero = (bus.multiplicand_in == '0) || (bus.multiplier_in == '0);

  // Handshake outputs decode the state; in_ready is also forced low while reset is asserted.
  assign bus.in_ready    = rst && (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.product_out = result_reg;

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      result_reg <= result_next;
    end
  end

  // Next-state and datapath control for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_next = bus.multiplicand_in;
          acc_next   = {1'b0, {WIDTH{1'b0}}, bus.multiplier_in};
          count_next = '0;
          if (ZERO_SKIP && operand_zero) begin
            acc_next    = '0;
            result_next = '0;
            state_next  = DONE;
          end else begin
            state_next  = CALC;
          end
        end
      end

      CALC: begin
        acc_next   = step;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          result_next = step[2*WIDTH-1:0];
          state_next  = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomised checks of the shift-and-add multiplier at W=8 (with and
// without zero skip) and W=32.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(8))  bus8  ();
  shift_add_multiplier_if #(.WIDTH(8))  busnz ();
  shift_add_multiplier_if #(.WIDTH(32)) bus32 ();

  shift_add_multiplier #(.WIDTH(8), .ZERO_SKIP(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave));
  shift_add_multiplier #(.WIDTH(8), .ZERO_SKIP(1'b0)) u_dutnz (
    .clk(clk), .rst(rst), .bus(busnz.slave));
  shift_add_multiplier #(.WIDTH(32), .ZERO_SKIP(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32.slave));

  // Stimulus helpers: called #1 after a rising edge; return #1 after the accept edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!bus8.in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!bus8.in_ready) begin
      tests++; failures++;
      $display("FAIL accept8_timeout: in_ready=%b required 1", bus8.in_ready);
    end
    bus8.multiplicand_in = a; bus8.multiplier_in = b; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.multiplicand_in = 8'hC3; bus8.multiplier_in = 8'h3C;
  endtask

  task automatic accept_nz(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!busnz.in_ready && n < 60) begin @(posedge clk); #1; n++; end
    busnz.multiplicand_in = a; busnz.multiplier_in = b; busnz.in_valid = 1'b1;
    @(posedge clk); #1;
    busnz.in_valid = 1'b0;
  endtask

  task automatic accept32(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus32.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    bus32.multiplicand_in = a; bus32.multiplier_in = b; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0; bus32.multiplicand_in = 32'hDEADBEEF; bus32.multiplier_in = 32'h5A5A5A5A;
  endtask

  // lat = 1 means out_valid was already high just after the accept edge.
  task automatic wait8(output int lat);
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_nz(output int lat);
    lat = 1;
    while (!busnz.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (!bus32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", bus8.in_ready); end
    tests++;
    if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus8.out_valid); end
    tests++;
    if (bus8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus8.busy); end
    tests++;
    if (bus8.product_out !== 16'h0000) begin failures++; $display("FAIL reset_product: got %h required 0000", bus8.product_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b required 1", bus8.in_ready); end
    tests++;
    if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready32: got %b required 1", bus32.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    accept8(8'd13, 8'd11);
    tests++;
    if (bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
      failures++; $display("FAIL basic_busy: busy=%b in_ready=%b required 1/0", bus8.busy, bus8.in_ready);
    end
    wait8(lat);
    tests++;
    if (lat != 9) begin failures++; $display("FAIL basic_latency: got %0d required 9", lat); end
    tests++;
    if (bus8.product_out !== 16'h008F) begin failures++; $display("FAIL basic_13x11: got %h required 008F", bus8.product_out); end
    $display("[TB] 13 x 11 -> %h latency %0d", bus8.product_out, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    logic [7:0]  a_tab [4] = '{8'hFF, 8'h80, 8'hFF, 8'h01};
    logic [7:0]  b_tab [4] = '{8'hFF, 8'h02, 8'h01, 8'h01};
    logic [15:0] p_tab [4] = '{16'hFE01, 16'h0100, 16'h00FF, 16'h0001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept8(a_tab[i], b_tab[i]);
      wait8(lat);
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.product_out !== p_tab[i]) begin
        failures++;
        $display("FAIL carry_%0d: %h x %h got %h valid %b required %h", i, a_tab[i], b_tab[i], bus8.product_out, bus8.out_valid, p_tab[i]);
      end
      $display("[TB] %h x %h -> %h", a_tab[i], b_tab[i], bus8.product_out);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_skip();
    int lat;
    accept8(8'h00, 8'hA5);
    wait8(lat);
    tests++;
    if (lat != 1 || bus8.product_out !== 16'h0000) begin
      failures++; $display("FAIL zskip_0xA5: latency %0d product %h required 1/0000", lat, bus8.product_out);
    end
    @(posedge clk); #1;
    accept8(8'hA5, 8'h00);
    wait8(lat);
    tests++;
    if (lat != 1 || bus8.product_out !== 16'h0000) begin
      failures++; $display("FAIL zskip_A5x0: latency %0d product %h required 1/0000", lat, bus8.product_out);
    end
    @(posedge clk); #1;
    accept_nz(8'h00, 8'hA5);
    wait_nz(lat);
    tests++;
    if (lat != 9 || busnz.product_out !== 16'h0000) begin
      failures++; $display("FAIL noskip_0xA5: latency %0d product %h required 9/0000", lat, busnz.product_out);
    end
    $display("[TB] zero operand without skip -> %h latency %0d", busnz.product_out, lat);
    @(posedge clk); #1;
    accept_nz(8'd13, 8'd11);
    wait_nz(lat);
    tests++;
    if (lat != 9 || busnz.product_out !== 16'h008F) begin
      failures++; $display("FAIL noskip_13x11: latency %0d product %h required 9/008F", lat, busnz.product_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus8.out_ready = 1'b0;
    accept8(8'h12, 8'h34);
    wait8(lat);
    tests++;
    if (bus8.product_out !== 16'h03A8) begin failures++; $display("FAIL bp_product: got %h required 03A8", bus8.product_out); end
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        bus8.multiplicand_in = 8'd2; bus8.multiplier_in = 8'd3; bus8.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.product_out !== 16'h03A8 || bus8.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid %b product %h in_ready %b required 1/03A8/0", i, bus8.out_valid, bus8.product_out, bus8.in_ready);
      end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.product_out !== 16'h03A8) begin
      failures++;
      $display("FAIL bp_release: in_ready %b valid %b busy %b product %h required 1/0/0/03A8", bus8.in_ready, bus8.out_valid, bus8.busy, bus8.product_out);
    end
    // The held in_valid is accepted on this IDLE cycle.
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    tests++;
    if (bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: busy %b in_ready %b required 1/0", bus8.busy, bus8.in_ready);
    end
    wait8(lat);
    tests++;
    if (lat != 9 || bus8.product_out !== 16'h0006) begin
      failures++; $display("FAIL b2b_2x3: latency %0d product %h required 9/0006", lat, bus8.product_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int  lat;
    bit  seen = 1'b0;
    accept8(8'h55, 8'h33);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b0 || bus8.product_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_outputs: busy %b valid %b in_ready %b product %h required 0/0/0/0000", bus8.busy, bus8.out_valid, bus8.in_ready, bus8.product_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus8.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen) begin failures++; $display("FAIL midreset_no_result: out_valid seen 1 required 0"); end
    accept8(8'd7, 8'd6);
    wait8(lat);
    tests++;
    if (lat != 9 || bus8.product_out !== 16'h002A) begin
      failures++; $display("FAIL midreset_7x6: latency %0d product %h required 9/002A", lat, bus8.product_out);
    end
    $display("[TB] after abort 7 x 6 -> %h", bus8.product_out);
    @(posedge clk); #1;
  endtask

  task automatic test_w32();
    logic [31:0] a_tab [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] b_tab [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0002};
    logic [63:0] p_tab [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0001_0000_0000, 64'h0000_0001_FFFF_FFFE};
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept32(a_tab[i], b_tab[i]);
      wait32(lat);
      tests++;
      if (lat != 33 || bus32.product_out !== p_tab[i]) begin
        failures++;
        $display("FAIL w32_%0d: latency %0d product %h required 33/%h", i, lat, bus32.product_out, p_tab[i]);
      end
      $display("[TB] W32 %h x %h -> %h", a_tab[i], b_tab[i], bus32.product_out);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [15:0] expect_p;
    for (int i = 0; i < 300; i++) begin
      int  cyc = 0;
      bit  got = 1'b0;
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      expect_p = {8'h00, a} * {8'h00, b};
      accept8(a, b);
      while (!got && cyc < 200) begin
        bus8.out_ready = 1'($urandom_range(0, 1));
        if (bus8.out_valid && bus8.out_ready) begin
          got = 1'b1;
          tests++;
          if (bus8.product_out !== expect_p) begin
            failures++; $display("FAIL random_%0d: %h x %h got %h required %h", i, a, b, bus8.product_out, expect_p);
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (!got) begin
        tests++; failures++;
        $display("FAIL random_timeout_%0d: out_valid %b required 1", i, bus8.out_valid);
      end
    end
    bus8.out_ready = 1'b1;
    $display("[TB] random W8 operand pairs done");
  endtask

  initial begin
    bus8.in_valid = 1'b0;  bus8.multiplicand_in = '0;  bus8.multiplier_in = '0;  bus8.out_ready = 1'b1;
    busnz.in_valid = 1'b0; busnz.multiplicand_in = '0; busnz.multiplier_in = '0; busnz.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.multiplicand_in = '0; bus32.multiplier_in = '0; bus32.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_zero_skip();
    test_backpressure();
    test_reset_mid();
    test_w32();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
